// File: rtl/counter_share_pkg.sv
// Shared definitions for the counter sharing controller: FSM state
// encoding, requester indices and the counter full-value derivation.
package counter_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } ctrl_state_e;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  // All-ones value of a WIDTH-bit counter (WIDTH up to 31).
  function automatic int unsigned cnt_max_f(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/share_up_counter.sv
// Loadable up-counter with full detect. Load has priority over UP; the
// counter saturates at the all-ones value instead of wrapping.
module share_up_counter
  import counter_share_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             up_i,
  input  logic [WIDTH-1:0] invalue_i,
  output logic [WIDTH-1:0] count_o,
  output logic             full_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(cnt_max_f(WIDTH));
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: load, increment below full, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = invalue_i;
    end else if (up_i && (count_q != CNT_MAX)) begin
      count_d = count_q + ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CNT_MAX);

endmodule

// File: rtl/counter_share_ctrl.sv
// Round-robin sequencer for one shared loadable up-counter. Each granted
// requester gets its start value loaded and counted up to all-ones, then a
// one-cycle done pulse. All outputs are registered from next-state values.
// Optional macro CTRL_ABORT_EN adds an ABORT input that cancels a run in
// LOAD or RUN without a done pulse.
module counter_share_ctrl
  import counter_share_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ0,
  input  logic             REQ1,
`ifdef CTRL_ABORT_EN
  input  logic             ABORT,
`endif
  input  logic [WIDTH-1:0] START0,
  input  logic [WIDTH-1:0] START1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             DONE0,
  output logic             DONE1,
  output logic             BUSY,
  output logic [WIDTH-1:0] Count
);

  ctrl_state_e state_q, state_d;
  logic        owner_q, owner_d;
  logic        ptr_q,   ptr_d;
  logic        gnt0_q,  gnt0_d;
  logic        gnt1_q,  gnt1_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        busy_q,  busy_d;

  logic             cnt_load;
  logic             cnt_up;
  logic             cnt_full;
  logic [WIDTH-1:0] cnt_invalue;

  // Arbitration, sequencing and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    cnt_load = 1'b0;
    cnt_up   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (REQ0 || REQ1) begin
          owner_d = (REQ0 && (!REQ1 || (ptr_q == REQ_ID0))) ? REQ_ID0 : REQ_ID1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_load = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_full) begin
          state_d = ST_DONE;
        end else begin
          cnt_up = 1'b1;
        end
      end
      ST_DONE: begin
        ptr_d   = ~owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef CTRL_ABORT_EN
    // Abort overrides the counter controls so Count holds its value.
    if (ABORT && ((state_q == ST_LOAD) || (state_q == ST_RUN))) begin
      state_d  = ST_IDLE;
      cnt_load = 1'b0;
      cnt_up   = 1'b0;
      ptr_d    = ~owner_q;
    end
`endif

    // Outputs are precomputed from the next state so they appear aligned
    // with the state they describe while still coming straight from flops.
    busy_d  = (state_d != ST_IDLE);
    gnt0_d  = busy_d && (owner_d == REQ_ID0);
    gnt1_d  = busy_d && (owner_d == REQ_ID1);
    done0_d = (state_d == ST_DONE) && (owner_d == REQ_ID0);
    done1_d = (state_d == ST_DONE) && (owner_d == REQ_ID1);
  end

  // State, arbitration and output registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      owner_q <= REQ_ID0;
      ptr_q   <= REQ_ID0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
    end
  end

  assign cnt_invalue = (owner_q == REQ_ID0) ? START0 : START1;

  share_up_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk_i    (CLK),
    .rst_ni   (RESET),
    .load_i   (cnt_load),
    .up_i     (cnt_up),
    .invalue_i(cnt_invalue),
    .count_o  (Count),
    .full_o   (cnt_full)
  );

  assign GNT0  = gnt0_q;
  assign GNT1  = gnt1_q;
  assign DONE0 = done0_q;
  assign DONE1 = done1_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_counter_share_ctrl.sv
// Directed bench for counter_share_ctrl (WIDTH=4). Each step pushes the
// expected per-cycle output vectors {GNT0,GNT1,DONE0,DONE1,BUSY,Count}
// derived from the latency rules, then pops and compares them cycle by cycle.
module tb_counter_share_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [3:0] start0, start1;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [3:0] count;
`ifdef CTRL_ABORT_EN
  logic       abort;
`endif

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [3:0]  last_cnt    = 4'd0;

  typedef struct {
    string      tag;
    logic [8:0] v;
  } exp_t;

  exp_t sb[$];

  counter_share_ctrl #(
    .WIDTH(4)
  ) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .REQ0  (req0),
    .REQ1  (req1),
`ifdef CTRL_ABORT_EN
    .ABORT (abort),
`endif
    .START0(start0),
    .START1(start1),
    .GNT0  (gnt0),
    .GNT1  (gnt1),
    .DONE0 (done0),
    .DONE1 (done1),
    .BUSY  (busy),
    .Count (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {gnt0, gnt1, done0, done1, busy, count};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (g0 g1 d0 d1 busy cnt)", tag, obs, exp);
    end
  endtask

  function automatic void push_ent(input string tag, input logic g0, input logic g1,
                                   input logic d0, input logic d1, input logic b,
                                   input logic [3:0] c);
    exp_t e;
    e.tag = tag;
    e.v   = {g0, g1, d0, d1, b, c};
    sb.push_back(e);
  endfunction

  // Expected trace of a granted run whose request was sampled at cycle t:
  // LOAD at t+1, Count=s..15 from t+2, DONE, then the following IDLE cycle.
  function automatic void push_run(input string tag, input logic o,
                                   input int unsigned s, input logic [3:0] prev);
    logic g0, g1;
    g0 = (o == 1'b0);
    g1 = (o == 1'b1);
    push_ent({tag, "_load"}, g0, g1, 1'b0, 1'b0, 1'b1, prev);
    for (int unsigned c = s; c <= 15; c++) begin
      push_ent($sformatf("%s_run%0d", tag, c), g0, g1, 1'b0, 1'b0, 1'b1, 4'(c));
    end
    push_ent({tag, "_done"}, g0, g1, g0, g1, 1'b1, 4'hF);
    push_ent({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
    last_cnt = 4'hF;
  endfunction

  task automatic drain(input int unsigned n);
    exp_t e;
    repeat (n) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL scoreboard: observed empty queue expected an entry");
      end else begin
        e = sb.pop_front();
        check(e.tag, e.v);
      end
    end
  endtask

  // Single request held for one cycle, run drained to the idle cycle.
  task automatic do_single(input string tag, input logic o, input logic [3:0] s);
    if (o) begin
      start1 = s;
      req1   = 1'b1;
    end else begin
      start0 = s;
      req0   = 1'b1;
    end
    push_run(tag, o, 32'(s), last_cnt);
    drain(1);
    req0 = 1'b0;
    req1 = 1'b0;
    drain(sb.size());
  endtask

  initial begin
    rst_n  = 1'b0;
    req0   = 1'b0;
    req1   = 1'b0;
    start0 = 4'd0;
    start1 = 4'd0;
`ifdef CTRL_ABORT_EN
    abort  = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    check("reset", 9'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 9'd0);

    // Both requesting from reset: 0, then 1, then 0 again.
    start0 = 4'd14;
    start1 = 4'd13;
    req0   = 1'b1;
    req1   = 1'b1;
    push_run("rr0a", 1'b0, 14, 4'd0);
    push_run("rr1",  1'b1, 13, 4'hF);
    push_run("rr0b", 1'b0, 14, 4'hF);
    drain(sb.size() - 4);
    req0 = 1'b0;
    req1 = 1'b0;
    drain(sb.size());

    // Basic run from 12.
    do_single("s0_12", 1'b0, 4'd12);

    // Boundary start values on requester 1.
    do_single("s1_15", 1'b1, 4'd15);
    do_single("s1_0",  1'b1, 4'd0);

    // REQ dropped and START changed mid-run: sequence unchanged.
    start0 = 4'd10;
    req0   = 1'b1;
    push_run("chg", 1'b0, 10, last_cnt);
    drain(3);
    req0   = 1'b0;
    start0 = 4'd3;
    drain(sb.size());

    // Asynchronous reset at Count=9 (pointer currently favours requester 1).
    start0 = 4'd5;
    req0   = 1'b1;
    push_run("rst", 1'b0, 5, last_cnt);
    drain(1);
    req0 = 1'b0;
    drain(5);
    rst_n = 1'b0;
    #1;
    check("rst_async", 9'd0);
    sb.delete();
    last_cnt = 4'd0;
    @(negedge clk);
    check("rst_hold", 9'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_idle", 9'd0);

    // Pointer back at requester 0 after reset.
    start0 = 4'd15;
    start1 = 4'd15;
    req0   = 1'b1;
    req1   = 1'b1;
    push_run("ptr0", 1'b0, 15, 4'd0);
    push_run("ptr1", 1'b1, 15, 4'hF);
    drain(sb.size() - 3);
    req0 = 1'b0;
    req1 = 1'b0;
    drain(sb.size());

`ifdef CTRL_ABORT_EN
    // Abort at Count=7 with requester 1 pending.
    start0 = 4'd4;
    start1 = 4'd14;
    req0   = 1'b1;
    req1   = 1'b1;
    push_ent("ab_load", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, last_cnt);
    for (int unsigned c = 4; c <= 7; c++) begin
      push_ent($sformatf("ab_run%0d", c), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'(c));
    end
    drain(5);
    abort = 1'b1;
    req0  = 1'b0;
    push_ent("ab_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7);
    push_run("ab_next", 1'b1, 14, 4'd7);
    drain(1);
    abort = 1'b0;
    drain(1);
    req1 = 1'b0;
    drain(sb.size());
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
